// File: rtl/maxpool_ctrl.sv
// 2x2 stride-2 max-pool sequencer: walks a feature map in a registered-output memory and streams one pooled value per window.
// Optional fused ReLU on the output register when MAXPOOL_RELU_EN is defined.
module maxpool_ctrl #(
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int OUT_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OUT_AW-1:0] out_idx
);

  localparam int PW   = IMG_W / 2;
  localparam int PH   = IMG_H / 2;
  localparam int NWIN = PW * PH;

  typedef enum logic [2:0] {IDLE, RD, WAIT, OUT, FIN} state_t;

  state_t                    state;
  logic [1:0]                k;
  logic [ADDR_W-1:0]         col;
  logic [ADDR_W-1:0]         row_base;
  logic [ADDR_W-1:0]         win_base;
  logic                      cap_en;
  logic                      cap_first;
  logic signed [DATA_W-1:0]  max_q;

  logic signed [DATA_W-1:0]  rd_s;
  logic signed [DATA_W-1:0]  max_next;
  logic signed [DATA_W-1:0]  pool_val;
  logic                      last_col;
  logic                      last_win;
  logic [ADDR_W-1:0]         next_row_base;
  logic [ADDR_W-1:0]         next_win_base;

  function automatic logic [ADDR_W-1:0] win_off(input logic [1:0] kk);
    case (kk)
      2'd0:    win_off = '0;
      2'd1:    win_off = ADDR_W'(1);
      2'd2:    win_off = ADDR_W'(IMG_W);
      default: win_off = ADDR_W'(IMG_W + 1);
    endcase
  endfunction

  // Element 0 of a window overwrites the running max; later elements compete signed.
  assign rd_s     = $signed(rd_data);
  assign max_next = (cap_first || (rd_s > max_q)) ? rd_s : max_q;

`ifdef MAXPOOL_RELU_EN
  assign pool_val = max_next[DATA_W-1] ? '0 : max_next;
`else
  assign pool_val = max_next;
`endif

  assign last_col      = (col == ADDR_W'(PW - 1));
  assign last_win      = (out_idx == OUT_AW'(NWIN - 1));
  assign next_row_base = row_base + ADDR_W'(2 * IMG_W);
  assign next_win_base = last_col ? next_row_base : win_base + ADDR_W'(2);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers (max, out_data, addresses) are reset too so
      // no stale value from an aborted run can ever appear on the outputs.
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      k         <= '0;
      col       <= '0;
      row_base  <= '0;
      win_base  <= '0;
      cap_en    <= 1'b0;
      cap_first <= 1'b0;
      max_q     <= '0;
    end else begin
      // Memory data lags rd_en by one cycle; track which element arrives next.
      cap_en    <= rd_en;
      cap_first <= (state == RD) && (k == 2'd0);
      if (cap_en) max_q <= max_next;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= RD;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            rd_addr  <= '0;
            k        <= '0;
            col      <= '0;
            row_base <= '0;
            win_base <= '0;
            out_idx  <= '0;
          end
        end

        RD: begin
          k <= k + 2'd1;
          if (k == 2'd3) begin
            state <= WAIT;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= win_base + win_off(k + 2'd1);
          end
        end

        WAIT: begin
          out_data  <= pool_val;
          out_valid <= 1'b1;
          state     <= OUT;
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_win) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              col      <= last_col ? '0 : col + ADDR_W'(1);
              row_base <= last_col ? next_row_base : row_base;
              win_base <= next_win_base;
              rd_addr  <= next_win_base;
              rd_en    <= 1'b1;
              k        <= '0;
              out_idx  <= out_idx + OUT_AW'(1);
              state    <= RD;
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Scoreboard bench for maxpool_ctrl on an odd, non-square 7x5 map with a behavioural pooling model.
// Randomized memory contents and backpressure; directed reset, re-start and negative-window cases.
module tb_maxpool_ctrl;

  localparam int IMG_W  = 7;
  localparam int IMG_H  = 5;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int OUT_AW = 8;
  localparam int PW     = IMG_W / 2;
  localparam int PH     = IMG_H / 2;
  localparam int NWIN   = PW * PH;
  localparam int NPIX   = IMG_W * IMG_H;

  typedef struct {
    int     idx;
    longint data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [OUT_AW-1:0] out_idx;

  logic signed [DATA_W-1:0] mem [NPIX];
  logic [DATA_W-1:0]        rd_q;

  exp_t exp_q[$];
  int   addr_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   ready_low_pct = 0;

  maxpool_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .OUT_AW(OUT_AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-read-port memory with registered output.
  always @(posedge clk) if (rd_en) rd_q <= (int'(rd_addr) < NPIX) ? mem[rd_addr] : '0;
  assign rd_data = rd_q;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Randomized backpressure, driven just after the active edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = ($urandom_range(99) >= ready_low_pct);
    end
  end

  // Monitor: compares reads and output handshakes against the scoreboard queues.
  initial begin
    bit     held_v;
    longint held_d;
    int     held_i;
    exp_t   e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (rd_en) begin
          if (addr_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_extra: got rd_addr %0d expected no read", rd_addr);
          end else begin
            check("rd_addr", rd_addr, addr_q.pop_front());
          end
          check("rd_busy", busy, 1);
        end
        if (out_valid) begin
          check("no_rd_in_out", rd_en, 0);
          if (held_v) begin
            check("hold_data", $signed(out_data), held_d);
            check("hold_idx", out_idx, held_i);
          end
          if (out_ready) begin
            held_v = 1'b0;
            check("out_busy", busy, 1);
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL out_extra: got out_data %0d expected no output", $signed(out_data));
            end else begin
              e = exp_q.pop_front();
              check("out_data", $signed(out_data), e.data);
              check("out_idx", out_idx, e.idx);
            end
          end else begin
            stall_cnt++;
            held_v = 1'b1;
            held_d = $signed(out_data);
            held_i = out_idx;
          end
        end
      end
    end
  end

  // 0: ramp (pixel = address), 1: random, 2: random with window 0 = {-5,-2,-9,-3}, 3: all negative.
  task automatic fill(input int mode);
    for (int a = 0; a < NPIX; a++) begin
      case (mode)
        0:       mem[a] = DATA_W'(a);
        3:       mem[a] = -DATA_W'($urandom_range(32768, 1));
        default: mem[a] = DATA_W'($urandom);
      endcase
    end
    if (mode == 2) begin
      mem[0]         = -16'sd5;
      mem[1]         = -16'sd2;
      mem[IMG_W]     = -16'sd9;
      mem[IMG_W + 1] = -16'sd3;
    end
  endtask

  // Reference: floor-sized grid of 2x2 windows, row-major, four reads per window.
  task automatic build_expect();
    int     offs[4];
    int     b;
    longint m;
    offs = '{0, 1, IMG_W, IMG_W + 1};
    for (int wy = 0; wy < PH; wy++) begin
      for (int wx = 0; wx < PW; wx++) begin
        b = 2 * wy * IMG_W + 2 * wx;
        m = mem[b];
        for (int e = 0; e < 4; e++) begin
          addr_q.push_back(b + offs[e]);
          if (mem[b + offs[e]] > m) m = mem[b + offs[e]];
        end
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        exp_q.push_back('{wy * PW + wx, m});
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_map(input int low_pct, input bit repulse);
    int t0;
    int cyc_done;
    bit seen;
    build_expect();
    stall_cnt = 0;
    ready_low_pct = low_pct;
    pulse_start();
    t0 = cyc;
    seen = 1'b0;
    cyc_done = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      start = repulse && (i == 10);
      if (done) begin
        seen = 1'b1;
        cyc_done = cyc - t0 + 1;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    if (seen) begin
      check("done_cycle", cyc_done, 6 * NWIN + stall_cnt + 1);
      check("busy_at_done", busy, 0);
      check("valid_at_done", out_valid, 0);
    end
    check("out_q_left", exp_q.size(), 0);
    check("addr_q_left", addr_q.size(), 0);
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check("done_one_cycle", done, 0);
    ready_low_pct = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_idx"}, out_idx, 0);
  endtask

  task automatic reset_in_out();
    bit seen;
    fill(1);
    build_expect();
    ready_low_pct = 100;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("stall_reached", seen, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_rst");
    exp_q.delete();
    addr_q.delete();
    ready_low_pct = 0;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_rd_en", rd_en, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    fill(0); run_map(0, 1'b0);
    fill(1); run_map(40, 1'b0);
    fill(1); run_map(30, 1'b1);
    fill(2); run_map(0, 1'b0);
    fill(3); run_map(50, 1'b0);
    reset_in_out();
    fill(0); run_map(0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      fill(1);
      run_map(int'($urandom_range(60)), r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
